// File: rtl/card_shoe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// card_shoe : finite DECKS-deck shoe; deals one still-available rank per request
// Revision  : 1.0
// ----------------------------------------------------------------------------
module card_shoe #(
  parameter int DECKS = 1
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       deal_req,
  input  logic       reshuffle,
  output logic [3:0] new_card,
  output logic       card_valid,
  output logic       busy,
  output logic       shoe_empty,
  output logic [8:0] cards_left
);

  localparam logic [5:0] c_rank_full = 6'(4 * DECKS);
  localparam logic [8:0] c_shoe_full = 9'(52 * DECKS);
  localparam logic [3:0] c_rank_max  = 4'd13;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cand_free_q;
  logic [3:0]  cand_search_q, cand_search_d;
  logic [5:0]  remain_q [1:13];
  logic [5:0]  remain_d [1:13];
  logic [8:0]  cards_left_q, cards_left_d;
  logic [3:0]  new_card_q, new_card_d;
  logic        card_valid_q, card_valid_d;
  logic        w_hit;

  function automatic logic [3:0] next_rank(input logic [3:0] r);
    return (r == c_rank_max) ? 4'd1 : r + 4'd1;
  endfunction

  // cand_search only ever holds 1..13, so the lookup never leaves the store
  assign w_hit = (remain_q[cand_search_q] != 6'd0);

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cand_free_q   <= 4'd1;
      cand_search_q <= 4'd1;
      for (int r = 1; r <= 13; r++) begin
        remain_q[r] <= c_rank_full;
      end
      cards_left_q  <= c_shoe_full;
      new_card_q    <= 4'd0;
      card_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_free_q   <= next_rank(cand_free_q);
      cand_search_q <= cand_search_d;
      for (int r = 1; r <= 13; r++) begin
        remain_q[r] <= remain_d[r];
      end
      cards_left_q  <= cards_left_d;
      new_card_q    <= new_card_d;
      card_valid_q  <= card_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cand_search_d = cand_search_q;
    cards_left_d  = cards_left_q;
    new_card_d    = new_card_q;
    card_valid_d  = 1'b0;
    for (int r = 1; r <= 13; r++) begin
      remain_d[r] = remain_q[r];
    end

    // A refill overrides both a pending request and an in-flight search
    if (reshuffle) begin
      state_d      = ST_IDLE;
      cards_left_d = c_shoe_full;
      for (int r = 1; r <= 13; r++) begin
        remain_d[r] = c_rank_full;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (deal_req && (cards_left_q != 9'd0)) begin
            cand_search_d = cand_free_q;
            state_d       = ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (w_hit) begin
            new_card_d               = cand_search_q;
            card_valid_d             = 1'b1;
            remain_d[cand_search_q]  = remain_q[cand_search_q] - 6'd1;
            cards_left_d             = cards_left_q - 9'd1;
            state_d                  = ST_IDLE;
          end else begin
            cand_search_d = next_rank(cand_search_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign new_card   = new_card_q;
  assign card_valid = card_valid_q;
  assign busy       = (state_q == ST_SEARCH);
  assign cards_left = cards_left_q;
  assign shoe_empty = (cards_left_q == 9'd0);

endmodule
`default_nettype wire

// File: tb/tb_card_shoe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_card_shoe : randomized deals against a rank-count model of the shoe
// Revision     : 1.0
// ----------------------------------------------------------------------------
module tb_card_shoe;

  localparam int DECKS    = 1;
  localparam int FULL     = 52 * DECKS;
  localparam int PER_RANK = 4 * DECKS;

  logic       slow_clock = 1'b0;
  logic       reset      = 1'b1;
  logic       deal_req   = 1'b0;
  logic       reshuffle  = 1'b0;
  logic [3:0] new_card;
  logic       card_valid;
  logic       busy;
  logic       shoe_empty;
  logic [8:0] cards_left;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;
  int rst_edge = 0;
  int rem  [1:13];
  int hist [1:13];
  int left;

  card_shoe #(.DECKS(DECKS)) u_dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .deal_req   (deal_req),
    .reshuffle  (reshuffle),
    .new_card   (new_card),
    .card_valid (card_valid),
    .busy       (busy),
    .shoe_empty (shoe_empty),
    .cards_left (cards_left)
  );

  always #5 slow_clock = ~slow_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then park on the falling edge for sampling/driving
  task automatic step();
    @(posedge slow_clock);
    edge_no++;
    @(negedge slow_clock);
  endtask

  // Rank the free counter presents at edge e: 1 in the first cycle after reset
  function automatic int free_at(input int e);
    return ((e - rst_edge - 1) % 13) + 1;
  endfunction

  task automatic model_refill();
    for (int r = 1; r <= 13; r++) rem[r] = PER_RANK;
    left = FULL;
  endtask

  task automatic check_full_idle(input string tag);
    check_eq({tag, "_valid"}, card_valid, 0);
    check_eq({tag, "_busy"},  busy, 0);
    check_eq({tag, "_left"},  cards_left, FULL);
    check_eq({tag, "_empty"}, shoe_empty, 0);
  endtask

  // target=0: random idle gap; otherwise wait until the free counter shows target
  task automatic do_deal(input int target, input bit noise);
    int         start;
    int         r;
    int         k;
    int         guard;
    logic [3:0] prev;
    if (target == 0) begin
      repeat ($urandom_range(0, 3)) step();
    end else begin
      guard = 0;
      while (free_at(edge_no + 1) != target && guard < 14) begin
        step();
        guard++;
      end
    end
    prev     = new_card;
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    start    = free_at(edge_no);
    if (left == 0) begin
      repeat (3) begin
        check_eq("drop_valid", card_valid, 0);
        check_eq("drop_busy", busy, 0);
        step();
      end
      check_eq("drop_card", new_card, prev);
      check_eq("drop_left", cards_left, 0);
      return;
    end
    r = start;
    k = 0;
    while (rem[r] == 0) begin
      r = (r % 13) + 1;
      k++;
    end
    for (int i = 0; i <= k; i++) begin
      check_eq("search_busy", busy, 1);
      check_eq("search_valid", card_valid, 0);
      if (noise) deal_req = 1'($urandom_range(0, 1));
      step();
    end
    deal_req = 1'b0;
    rem[r]--;
    left--;
    check_eq("deal_valid", card_valid, 1);
    check_eq("deal_card", new_card, r);
    check_eq("deal_busy", busy, 0);
    check_eq("deal_left", cards_left, left);
    check_eq("deal_empty", shoe_empty, (left == 0));
    if (new_card >= 1 && new_card <= 13) hist[new_card]++;
  endtask

  initial begin
    logic [3:0] prev;
    model_refill();
    for (int r = 1; r <= 13; r++) hist[r] = 0;

    step();
    step();
    rst_edge = edge_no;
    reset    = 1'b0;
    check_eq("rst_card", new_card, 0);
    check_full_idle("rst");

    // Basic deal while the free counter shows 5
    do_deal(5, 0);

    // Exhaust rank 7; the fifth request slips to rank 8
    for (int i = 0; i < 5; i++) do_deal(7, 0);
    check_eq("rank7_model", rem[7], 0);

    // Refill and request on the same idle cycle
    deal_req  = 1'b1;
    reshuffle = 1'b1;
    step();
    deal_req  = 1'b0;
    reshuffle = 1'b0;
    model_refill();
    check_full_idle("simul");
    step();
    check_full_idle("simul_next");

    // Random drain with requests sprinkled during searches
    for (int r = 1; r <= 13; r++) hist[r] = 0;
    for (int i = 0; i < FULL; i++) do_deal(0, 1);
    check_eq("drain_empty", shoe_empty, 1);
    check_eq("drain_left", cards_left, 0);
    for (int r = 1; r <= 13; r++) check_eq("drain_hist", hist[r], PER_RANK);
    do_deal(0, 0);

    // Empty ranks 1..12, then abort a long search with a refill
    reshuffle = 1'b1;
    step();
    reshuffle = 1'b0;
    model_refill();
    check_full_idle("refill");
    for (int r = 1; r <= 12; r++) begin
      while (rem[r] > 0) do_deal(r, 0);
    end
    check_eq("r12_left", cards_left, PER_RANK);
    while (free_at(edge_no + 1) != 1) step();
    prev     = new_card;
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    step();
    step();
    check_eq("abort_busy_pre", busy, 1);
    reshuffle = 1'b1;
    step();
    reshuffle = 1'b0;
    model_refill();
    check_full_idle("abort");
    check_eq("abort_card", new_card, prev);
    step();
    check_full_idle("abort_next");

    // Reset in the cycle after the request is sampled
    do_deal(0, 0);
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    check_eq("prerst_busy", busy, 1);
    reset = 1'b1;
    step();
    rst_edge = edge_no;
    reset    = 1'b0;
    model_refill();
    check_eq("midrst_card", new_card, 0);
    check_full_idle("midrst");

    // A second random drain after reset
    for (int r = 1; r <= 13; r++) hist[r] = 0;
    for (int i = 0; i < FULL; i++) do_deal(0, 1);
    check_eq("drain2_empty", shoe_empty, 1);
    for (int r = 1; r <= 13; r++) check_eq("drain2_hist", hist[r], PER_RANK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
